// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with undelayed
// coordinates, plus sync/blank/frame markers delayed to line up with
// the registered pixel data path.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT     = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Pipeline word layout: {hs, vs, blank, line, frame}; idle = syncs high.
  localparam logic [4:0] PIPE_IDLE = 5'b11000;

  logic [9:0] hc;
  logic [9:0] vc;
  logic [4:0] raw;
  logic [4:0] pipe [PIPE_DELAY];

  // Horizontal/vertical raster counters.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Raw decode of the current counter position.
  always_comb begin
    raw    = PIPE_IDLE;
    raw[4] = !((hc >= HS_START) && (hc < HS_END));
    raw[3] = !((vc >= VS_START) && (vc < VS_END));
    raw[2] = (hc < H_ACT) && (vc < V_ACT);
    raw[1] = (hc == 10'd0);
    raw[0] = (hc == 10'd0) && (vc == 10'd0);
  end

  // Delay line so markers coincide with the registered pixel data.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= PIPE_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Count delayed frame markers; wraps naturally at 8 bits.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 8'd1;
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign hs          = pipe[PIPE_DELAY-1][4];
  assign vs          = pipe[PIPE_DELAY-1][3];
  assign blank       = pipe[PIPE_DELAY-1][2];
  assign line_start  = pipe[PIPE_DELAY-1][1];
  assign frame_start = pipe[PIPE_DELAY-1][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken raster (16x11) for frame-level
// and wrap checks, plus a default 800x525 instance for line timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] s_x, s_y, b_x, b_y;
  logic       s_hs, s_vs, s_bl, s_ln, s_fs;
  logic       b_hs, b_vs, b_bl, b_ln, b_fs;
  logic [7:0] s_fc, b_fc;

  // Small raster: H 8+2+3+3=16 (hs low 10..12), V 6+1+2+2=11 (vs low 7..8).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DELAY(2)
  ) dut_s (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y),
    .hs(s_hs), .vs(s_vs), .blank(s_bl), .line_start(s_ln),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y),
    .hs(b_hs), .vs(b_vs), .blank(b_bl), .line_start(b_ln),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  typedef struct {
    int n; int x; int y;
    int hs; int vs; int bl; int ln; int fr; int fc;
  } vec_t;

  vec_t tbl [19];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (5) step();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Walks n = 0..179 edges after release and checks every table entry.
  task automatic run_table(input string tag);
    int idx = 0;
    for (int n = 0; n <= 179; n++) begin
      if (n > 0) step();
      if (idx < 19 && tbl[idx].n == n) begin
        chk({tag, "_x"},  int'(s_x),  tbl[idx].x);
        chk({tag, "_y"},  int'(s_y),  tbl[idx].y);
        chk({tag, "_hs"}, int'(s_hs), tbl[idx].hs);
        chk({tag, "_vs"}, int'(s_vs), tbl[idx].vs);
        chk({tag, "_bl"}, int'(s_bl), tbl[idx].bl);
        chk({tag, "_ln"}, int'(s_ln), tbl[idx].ln);
        chk({tag, "_fr"}, int'(s_fs), tbl[idx].fr);
        chk({tag, "_fc"}, int'(s_fc), tbl[idx].fc);
        idx++;
      end
    end
  endtask

  initial begin
    int cnt, hs_low, hs_first, hs_last, bl_hi, ln_at, prev_cyc;
    bit timed_out;

    //             n    x  y  hs vs bl ln fr fc
    tbl[0]  = '{  0,   0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{  1,   1, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{  2,   2, 0, 1, 1, 1, 1, 1, 0};
    tbl[3]  = '{  3,   3, 0, 1, 1, 1, 0, 0, 1};
    tbl[4]  = '{  9,   9, 0, 1, 1, 1, 0, 0, 1};
    tbl[5]  = '{ 10,  10, 0, 1, 1, 0, 0, 0, 1};
    tbl[6]  = '{ 12,  12, 0, 0, 1, 0, 0, 0, 1};
    tbl[7]  = '{ 14,  14, 0, 0, 1, 0, 0, 0, 1};
    tbl[8]  = '{ 15,  15, 0, 1, 1, 0, 0, 0, 1};
    tbl[9]  = '{ 16,   0, 1, 1, 1, 0, 0, 0, 1};
    tbl[10] = '{ 18,   2, 1, 1, 1, 1, 1, 0, 1};
    tbl[11] = '{ 89,   9, 5, 1, 1, 1, 0, 0, 1};
    tbl[12] = '{ 98,   2, 6, 1, 1, 0, 1, 0, 1};
    tbl[13] = '{114,   2, 7, 1, 0, 0, 1, 0, 1};
    tbl[14] = '{145,   1, 9, 1, 0, 0, 0, 0, 1};
    tbl[15] = '{146,   2, 9, 1, 1, 0, 1, 0, 1};
    tbl[16] = '{176,   0, 0, 1, 1, 0, 0, 0, 1};
    tbl[17] = '{178,   2, 0, 1, 1, 1, 1, 1, 1};
    tbl[18] = '{179,   3, 0, 1, 1, 1, 0, 0, 2};

    // Reset state on the full-size instance.
    repeat (5) step();
    chk("rst_b_x",  int'(b_x),  0);
    chk("rst_b_y",  int'(b_y),  0);
    chk("rst_b_hs", int'(b_hs), 1);
    chk("rst_b_vs", int'(b_vs), 1);
    chk("rst_b_bl", int'(b_bl), 0);
    chk("rst_b_fc", int'(b_fc), 0);

    do_reset();
    run_table("t1");

    // One full 800-clock line on the default raster.
    timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (b_ln) begin timed_out = 1'b0; break; end
    end
    chk("b_line_wait_timeout", int'(timed_out), 0);
    hs_low = 0; hs_first = -1; hs_last = -1; bl_hi = 0; ln_at = -1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) begin
        step();
        if (b_ln && ln_at < 0) ln_at = i;
      end
      if (!b_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (b_bl) bl_hi++;
    end
    step();
    if (b_ln && ln_at < 0) ln_at = 800;
    chk("b_hs_low_count", hs_low, 96);
    chk("b_hs_first", hs_first, 656);
    chk("b_hs_last", hs_last, 751);
    chk("b_blank_count", bl_hi, 640);
    chk("b_line_period", ln_at, 800);

    // Asynchronous reset in the middle of a visible line.
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_x == 10'd3 && s_y == 10'd4) begin timed_out = 1'b0; break; end
    end
    chk("mid_wait_timeout", int'(timed_out), 0);
    chk("mid_pre_bl", int'(s_bl), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_x",  int'(s_x),  0);
    chk("mid_y",  int'(s_y),  0);
    chk("mid_hs", int'(s_hs), 1);
    chk("mid_vs", int'(s_vs), 1);
    chk("mid_bl", int'(s_bl), 0);
    chk("mid_ln", int'(s_ln), 0);
    chk("mid_fr", int'(s_fs), 0);
    chk("mid_fc", int'(s_fc), 0);
    do_reset();
    run_table("t2");

    // frame_count wrap over 256 frames, with 176-clock frame period.
    do_reset();
    prev_cyc = 0;
    for (int k = 0; k <= 256; k++) begin
      cnt = 0;
      while (!s_fs && cnt < 400) begin step(); cnt++; end
      if (!s_fs) begin
        chk("wrap_fs_timeout", cnt, 0);
        break;
      end
      chk("wrap_fc_at_pulse", int'(s_fc), k % 256);
      if (k > 0) chk("wrap_frame_period", cyc - prev_cyc, 176);
      prev_cyc = cyc;
      step();
      chk("wrap_fs_width", int'(s_fs), 0);
      chk("wrap_fc_after", int'(s_fc), (k + 1) % 256);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
